// File: rtl/hazard_forward_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_forward_ctrl_if
// Bundle between the pipeline datapath and the hazard/forwarding controller.
//   master : datapath side. Drives the decode-stage instruction info and
//            HoldAll, and receives the mux selects and the stall/flush controls.
//   slave  : controller side, with the opposite directions.
// Decode-side signals:
//   RsD/RtD, UseRsD/UseRtD, BranchD, WriteRegD, RegWriteD, MemtoRegD
// Freeze input:
//   HoldAll
// Controller outputs:
//   ForwardAD/BD, ForwardAE/BE, StallF, StallD, FlushE
// -----------------------------------------------------------------------------
interface hazard_forward_ctrl_if #(
    parameter int REG_W = 5
);
    logic [REG_W-1:0] RsD;
    logic [REG_W-1:0] RtD;
    logic             UseRsD;
    logic             UseRtD;
    logic             BranchD;
    logic [REG_W-1:0] WriteRegD;
    logic             RegWriteD;
    logic             MemtoRegD;
    logic             HoldAll;
    logic [1:0]       ForwardAD;
    logic [1:0]       ForwardBD;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             FlushE;

    modport master (
        output RsD, RtD, UseRsD, UseRtD, BranchD, WriteRegD, RegWriteD, MemtoRegD, HoldAll,
        input  ForwardAD, ForwardBD, ForwardAE, ForwardBE, StallF, StallD, FlushE
    );

    modport slave (
        input  RsD, RtD, UseRsD, UseRtD, BranchD, WriteRegD, RegWriteD, MemtoRegD, HoldAll,
        output ForwardAD, ForwardBD, ForwardAE, ForwardBE, StallF, StallD, FlushE
    );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_forward_ctrl
// Hazard and forwarding controller for a 5-stage MIPS pipeline. It keeps its
// own copy of the destination info of the instructions in E, M and W. That
// copy is built from the decode-stage fields. From these slots and the current
// decode instruction it produces:
//   - the decode-stage forwarding selects for the branch comparator,
//   - the execute-stage forwarding selects for the ALU operands,
//   - StallF/StallD/FlushE for load-use and branch-compare hazards.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high. Clears the slot valid bits and forces
//            all outputs to 0 while asserted.
//   hz     : hazard_forward_ctrl_if.slave (decode info in, selects/stalls out)
// Build option:
//   FWD_BRANCH_FROM_E_EN
//     Defined   : a branch in D may take the E-stage ALU result
//                 (ForwardxD = 10).
//     Undefined : a branch in D that depends on any E-stage writer stalls one
//                 cycle. It then forwards from M (ForwardxD = 01).
// Select encodings:
//   ForwardxD : 00 register file, 01 ALUOutM, 10 ALUOut(E)
//   ForwardxE : 00 register file, 01 ResultW, 10 ALUOutM
// -----------------------------------------------------------------------------
module hazard_forward_ctrl #(
    parameter int REG_W = 5
) (
    input logic                  clk,
    input logic                  reset,
    hazard_forward_ctrl_if.slave hz
);

    // Pipeline slots
    logic             e_valid_reg, e_reg_write_reg, e_mem_to_reg_reg;
    logic [REG_W-1:0] e_dest_reg, e_rs_reg, e_rt_reg;
    logic             e_use_rs_reg, e_use_rt_reg;
    logic             m_valid_reg, m_reg_write_reg, m_mem_to_reg_reg;
    logic [REG_W-1:0] m_dest_reg;
    logic             w_valid_reg, w_reg_write_reg;
    logic [REG_W-1:0] w_dest_reg;

    // Register 0 is hard-wired, so it never matches a producer.
    function automatic logic slot_match(input logic valid, input logic reg_write,
                                        input logic [REG_W-1:0] dest,
                                        input logic [REG_W-1:0] src);
        return valid && reg_write && (dest == src) && (src != '0);
    endfunction

    // Operand 0 = Rs (A side), operand 1 = Rt (B side)
    logic [REG_W-1:0] src_d [2];
    logic             use_d [2];
    logic [REG_W-1:0] src_e [2];
    logic             use_e [2];
    logic [1:0]       fwd_d [2];
    logic [1:0]       fwd_e [2];
    logic             lw_hit [2];
    logic             br_hit [2];
    logic             stall;

    assign src_d[0] = hz.RsD;
    assign src_d[1] = hz.RtD;
    assign use_d[0] = hz.UseRsD;
    assign use_d[1] = hz.UseRtD;
    assign src_e[0] = e_rs_reg;
    assign src_e[1] = e_rt_reg;
    assign use_e[0] = e_use_rs_reg;
    assign use_e[1] = e_use_rt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            logic e_hit_d, m_hit_d, m_hit_e, w_hit_e;

            assign e_hit_d = use_d[gi] && slot_match(e_valid_reg, e_reg_write_reg, e_dest_reg, src_d[gi]);
            assign m_hit_d = use_d[gi] && slot_match(m_valid_reg, m_reg_write_reg, m_dest_reg, src_d[gi]);
            assign m_hit_e = use_e[gi] && slot_match(m_valid_reg, m_reg_write_reg, m_dest_reg, src_e[gi]);
            assign w_hit_e = use_e[gi] && slot_match(w_valid_reg, w_reg_write_reg, w_dest_reg, src_e[gi]);

            // M is younger than W, so its value wins.
            assign fwd_e[gi] = m_hit_e ? 2'b10 : (w_hit_e ? 2'b01 : 2'b00);

            // A load result is not ready in E, or in M for the decode-stage
            // compare. Those cases stall, so no select for them is needed.
`ifdef FWD_BRANCH_FROM_E_EN
            assign fwd_d[gi] = !hz.BranchD                      ? 2'b00 :
                               (e_hit_d && !e_mem_to_reg_reg)   ? 2'b10 :
                               (m_hit_d && !m_mem_to_reg_reg)   ? 2'b01 : 2'b00;
            assign br_hit[gi] = hz.BranchD && m_hit_d && m_mem_to_reg_reg;
`else
            assign fwd_d[gi] = !hz.BranchD                      ? 2'b00 :
                               (m_hit_d && !m_mem_to_reg_reg)   ? 2'b01 : 2'b00;
            // Without the E path, any branch dependency on E waits one cycle.
            assign br_hit[gi] = hz.BranchD && ((m_hit_d && m_mem_to_reg_reg) || e_hit_d);
`endif
            assign lw_hit[gi] = e_hit_d && e_mem_to_reg_reg;
        end
    endgenerate

    assign stall = lw_hit[0] || lw_hit[1] || br_hit[0] || br_hit[1];

    always_comb begin
        hz.ForwardAD = 2'b00;
        hz.ForwardBD = 2'b00;
        hz.ForwardAE = 2'b00;
        hz.ForwardBE = 2'b00;
        hz.StallF    = 1'b0;
        hz.StallD    = 1'b0;
        hz.FlushE    = 1'b0;
        if (!reset) begin
            hz.ForwardAD = fwd_d[0];
            hz.ForwardBD = fwd_d[1];
            hz.ForwardAE = fwd_e[0];
            hz.ForwardBE = fwd_e[1];
            if (hz.HoldAll) begin
                // Whole pipe frozen: hold F/D and keep E intact.
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
            end else begin
                hz.StallF = stall;
                hz.StallD = stall;
                hz.FlushE = stall;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_valid_reg <= 1'b0;
            m_valid_reg <= 1'b0;
            w_valid_reg <= 1'b0;
        end else if (!hz.HoldAll) begin
            w_valid_reg      <= m_valid_reg;
            w_reg_write_reg  <= m_reg_write_reg;
            w_dest_reg       <= m_dest_reg;
            m_valid_reg      <= e_valid_reg;
            m_reg_write_reg  <= e_reg_write_reg;
            m_mem_to_reg_reg <= e_mem_to_reg_reg;
            m_dest_reg       <= e_dest_reg;
            // A stalled decode instruction becomes a bubble in E. Clearing
            // the use bits keeps the bubble from raising stale E selects.
            e_valid_reg      <= !stall;
            e_reg_write_reg  <= hz.RegWriteD;
            e_mem_to_reg_reg <= hz.MemtoRegD;
            e_dest_reg       <= hz.WriteRegD;
            e_rs_reg         <= hz.RsD;
            e_rt_reg         <= hz.RtD;
            e_use_rs_reg     <= hz.UseRsD && !stall;
            e_use_rt_reg     <= hz.UseRtD && !stall;
        end
    end

endmodule
